// File: rtl/ifstore_bank_gen.sv
// ifmap store generator: drains an empty_n/read stream into NUM_BANKS ifmap SRAM banks,
// rows interleaved round-robin across banks, starting at a runtime base address.
module ifstore_bank_gen #(
   parameter int unsigned TBITS     = 64,
   parameter int unsigned ADDR_BITS = 11,
   parameter int unsigned NUM_BANKS = 3,
   parameter int unsigned COL_BITS  = 10,
   parameter int unsigned ROW_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_if_store,
   input  logic                 abort_if_store,
   input  logic [COL_BITS-1:0]  cfg_row_words,
   input  logic [ROW_BITS-1:0]  cfg_num_rows,
   input  logic [ADDR_BITS-1:0] cfg_base_addr,
   input  logic [TBITS-1:0]     ifstore_data_din,
   input  logic                 ifstore_empty_n_din,
   output logic                 ifstore_read_dout,
   output logic                 if_store_busy,
   output logic                 if_store_done,
   output logic [NUM_BANKS-1:0] cen_ifsram,
   output logic [NUM_BANKS-1:0] wen_ifsram,
   output logic [ADDR_BITS-1:0] addr_ifsram,
   output logic [TBITS-1:0]     data_ifsram
);

   localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic                 read_q, read_d;
   logic [COL_BITS-1:0]  col_q, col_d;
   logic [COL_BITS-1:0]  row_words_q, row_words_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [ROW_BITS-1:0]  num_rows_q, num_rows_d;
   logic [BANK_BITS-1:0] bank_q, bank_d;
   logic [ADDR_BITS-1:0] bank_base_q, bank_base_d;
   logic [ADDR_BITS-1:0] base_q, base_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [TBITS-1:0]     data_q, data_d;
   logic [NUM_BANKS-1:0] cen_q, cen_d;
   logic [NUM_BANKS-1:0] wen_q, wen_d;

   logic acc;
   logic last_word;
   logic last_acc;
   logic cfg_ok;

   assign acc       = read_q & ifstore_empty_n_din;
   assign last_word = (row_q == num_rows_q - ROW_BITS'(1)) &&
                      (col_q == row_words_q - COL_BITS'(1));
   assign last_acc  = acc & last_word;
   assign cfg_ok    = (cfg_row_words != '0) && (cfg_num_rows != '0);

   // Next-state: FSM, read request, address counters and the one-cycle write pipeline
   always_comb begin
      state_d     = state_q;
      read_d      = 1'b0;
      col_d       = col_q;
      row_d       = row_q;
      bank_d      = bank_q;
      bank_base_d = bank_base_q;
      row_words_d = row_words_q;
      num_rows_d  = num_rows_q;
      base_d      = base_q;
      addr_d      = addr_q;
      data_d      = data_q;
      cen_d       = '1;
      wen_d       = '1;

      // An accepted word is written next cycle, even if abort arrives alongside it
      if (acc) begin
         addr_d = base_q + bank_base_q + ADDR_BITS'(col_q);
         data_d = ifstore_data_din;
         cen_d  = ~(NUM_BANKS'(1) << bank_q);
         wen_d  = ~(NUM_BANKS'(1) << bank_q);
         if (col_q == row_words_q - COL_BITS'(1)) begin
            col_d = '0;
            row_d = row_q + ROW_BITS'(1);
            if (bank_q == BANK_BITS'(NUM_BANKS - 1)) begin
               bank_d      = '0;
               bank_base_d = bank_base_q + ADDR_BITS'(row_words_q);
            end else begin
               bank_d = bank_q + BANK_BITS'(1);
            end
         end else begin
            col_d = col_q + COL_BITS'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_if_store) begin
               row_words_d = cfg_row_words;
               num_rows_d  = cfg_num_rows;
               base_d      = cfg_base_addr;
               col_d       = '0;
               row_d       = '0;
               bank_d      = '0;
               bank_base_d = '0;
               state_d     = cfg_ok ? StLoad : StDone;
            end
         end
         StLoad: begin
            if (abort_if_store) begin
               state_d = StDone;
            end else if (last_acc) begin
               state_d = StDrain;
            end else begin
               read_d = ifstore_empty_n_din;
            end
         end
         StDrain: begin
            state_d = StDone;
         end
         StDone: begin
            state_d     = StIdle;
            col_d       = '0;
            row_d       = '0;
            bank_d      = '0;
            bank_base_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         read_q      <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         bank_q      <= '0;
         bank_base_q <= '0;
         row_words_q <= '0;
         num_rows_q  <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         cen_q       <= '1;
         wen_q       <= '1;
      end else begin
         state_q     <= state_d;
         read_q      <= read_d;
         col_q       <= col_d;
         row_q       <= row_d;
         bank_q      <= bank_d;
         bank_base_q <= bank_base_d;
         row_words_q <= row_words_d;
         num_rows_q  <= num_rows_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cen_q       <= cen_d;
         wen_q       <= wen_d;
      end
   end

   assign ifstore_read_dout = read_q;
   assign if_store_busy     = (state_q == StLoad);
   assign if_store_done     = (state_q == StDone);
   assign cen_ifsram        = cen_q;
   assign wen_ifsram        = wen_q;
   assign addr_ifsram       = addr_q;
   assign data_ifsram       = data_q;

endmodule

// File: tb/tb_ifstore_bank_gen.sv
// Bench for ifstore_bank_gen: a 3-bank instance checked against a write scoreboard and a
// 1-bank instance used for the address-wrap case.
`timescale 1ns/1ps
module tb_ifstore_bank_gen;

   localparam int TB = 64;
   localparam int AB = 11;
   localparam int NB = 3;
   localparam int CB = 10;
   localparam int RB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b0;

   // 3-bank instance
   logic          start = 1'b0, abort = 1'b0;
   logic [CB-1:0] cfg_rw = '0;
   logic [RB-1:0] cfg_rows = '0;
   logic [AB-1:0] cfg_base = '0;
   logic [TB-1:0] din = '0;
   logic          empty_n = 1'b0;
   logic          rd, busy, done;
   logic [NB-1:0] cen, wen;
   logic [AB-1:0] addr;
   logic [TB-1:0] dout;

   // 1-bank instance
   logic          start1 = 1'b0;
   logic [CB-1:0] cfg_rw1 = '0;
   logic [RB-1:0] cfg_rows1 = '0;
   logic [AB-1:0] cfg_base1 = '0;
   logic [TB-1:0] din1 = '0;
   logic          empty_n1 = 1'b1;
   logic          rd1, busy1, done1;
   logic [0:0]    cen1, wen1;
   logic [AB-1:0] addr1;
   logic [TB-1:0] dout1;

   ifstore_bank_gen #(.TBITS(TB), .ADDR_BITS(AB), .NUM_BANKS(NB), .COL_BITS(CB),
                      .ROW_BITS(RB)) dut (
      .clk(clk), .reset(reset), .start_if_store(start), .abort_if_store(abort),
      .cfg_row_words(cfg_rw), .cfg_num_rows(cfg_rows), .cfg_base_addr(cfg_base),
      .ifstore_data_din(din), .ifstore_empty_n_din(empty_n), .ifstore_read_dout(rd),
      .if_store_busy(busy), .if_store_done(done), .cen_ifsram(cen), .wen_ifsram(wen),
      .addr_ifsram(addr), .data_ifsram(dout));

   ifstore_bank_gen #(.TBITS(TB), .ADDR_BITS(AB), .NUM_BANKS(1), .COL_BITS(CB),
                      .ROW_BITS(RB)) dut1 (
      .clk(clk), .reset(reset), .start_if_store(start1), .abort_if_store(1'b0),
      .cfg_row_words(cfg_rw1), .cfg_num_rows(cfg_rows1), .cfg_base_addr(cfg_base1),
      .ifstore_data_din(din1), .ifstore_empty_n_din(empty_n1), .ifstore_read_dout(rd1),
      .if_store_busy(busy1), .if_store_done(done1), .cen_ifsram(cen1), .wen_ifsram(wen1),
      .addr_ifsram(addr1), .data_ifsram(dout1));

   typedef struct {
      logic [NB-1:0] cen;
      logic [AB-1:0] addr;
      logic [TB-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t obs1_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cnt = 0;
   int wr_cnt  = 0;
   int src_idx = 0;
   int idx1    = 0;
   bit src_on  = 1'b0;
   bit src_rand = 1'b0;
   bit acc_flag = 1'b0;

   function automatic logic [TB-1:0] word(input logic [7:0] tag, input int j);
      return {tag, 24'hC0FFEE, 32'(j)};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Expected writes in row-major order: row r lands in bank r%NB at base + (r/NB)*rw + col
   task automatic push_exp(input int rw, input int rows, input int base);
      wr_t e;
      int  j0 = src_idx;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < rw; c++) begin
            e.cen = '1;
            e.cen[r % NB] = 1'b0;
            e.addr = AB'((base + (r / NB) * rw + c) % (1 << AB));
            e.data = word(8'hA7, j0 + r * rw + c);
            exp_q.push_back(e);
         end
      end
   endtask

   // Negedge monitor: compares each write with the scoreboard, then drives the stream
   task automatic monitor();
      bit  wr;
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            acc_flag = 1'b0;
            empty_n  = 1'b0;
         end else begin
            wr = (cen !== '1) || (wen !== '1);
            if (wr || acc_flag) begin
               n_tests++;
               if (wr !== acc_flag) begin
                  n_fail++;
                  $display("FAIL write_vs_accept: write=%0b expected=%0b", wr, acc_flag);
               end
            end
            if (wr) begin
               wr_cnt++;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_write: cen=%b addr=%0d, expected no write", cen, addr);
               end else begin
                  e = exp_q.pop_front();
                  if (cen !== e.cen || wen !== e.cen || addr !== e.addr || dout !== e.data) begin
                     n_fail++;
                     $display("FAIL write: got cen=%b wen=%b addr=%0d data=%h, expected cen=%b addr=%0d data=%h",
                              cen, wen, addr, dout, e.cen, e.addr, e.data);
                  end
               end
            end
            empty_n = src_on && (!src_rand || ($urandom_range(0, 1) == 1));
            din = word(8'hA7, src_idx);
            acc_flag = rd && empty_n;
            if (acc_flag) begin
               acc_cnt++;
               src_idx++;
            end
            // 1-bank instance: log writes, always-ready stream
            if (cen1 === 1'b0) begin
               e.cen = {NB{1'b0}};
               e.cen[0] = wen1;
               e.addr = addr1;
               e.data = dout1;
               obs1_q.push_back(e);
            end
            din1 = word(8'h66, idx1);
            if (rd1) idx1++;
         end
      end
   endtask

   // Steps until done, clearing start after the first step; lat = steps taken or -1
   task automatic wait_done(input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         start = 1'b0;
         if (done) begin
            lat = i;
            return;
         end
      end
   endtask

   task automatic kick(input int rw, input int rows, input int base);
      cfg_rw   = CB'(rw);
      cfg_rows = RB'(rows);
      cfg_base = AB'(base);
      start    = 1'b1;
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_tests++;
      if (rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cen !== '1 || wen !== '1 ||
          addr !== '0 || dout !== '0) begin
         n_fail++;
         $display("FAIL %s: rd=%b busy=%b done=%b cen=%b wen=%b addr=%0d data=%h, expected 0 0 0 111 111 0 0",
                  name, rd, busy, done, cen, wen, addr, dout);
      end
   endtask

   task automatic test_reset();
      step();
      step();
      check_idle_outputs("reset_values");
      n_tests++;
      if (cen1 !== 1'b1 || wen1 !== 1'b1 || rd1 !== 1'b0 || addr1 !== '0) begin
         n_fail++;
         $display("FAIL reset_values_1bank: cen=%b wen=%b rd=%b addr=%0d, expected 1 1 0 0",
                  cen1, wen1, rd1, addr1);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int lat, w0;
      src_on = 1'b1;
      src_rand = 1'b0;
      w0 = wr_cnt;
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      wait_done(200, lat);
      check_int("basic_done_latency", lat, 15);
      check_int("basic_write_count", wr_cnt - w0, 12);
      check_int("basic_queue_left", exp_q.size(), 0);
      step();
      check_int("basic_busy_after", int'(busy), 0);
      check_int("basic_done_pulse_width", int'(done), 0);
   endtask

   task automatic test_long_rows();
      int lat, w0;
      w0 = wr_cnt;
      push_exp(264, 5, 16);
      kick(264, 5, 16);
      wait_done(2000, lat);
      check_int("rows_done_latency", lat, 1323);
      check_int("rows_write_count", wr_cnt - w0, 1320);
      check_int("rows_queue_left", exp_q.size(), 0);
      step();
   endtask

   task automatic test_stall();
      int lat, w0, a0;
      w0 = wr_cnt;
      a0 = acc_cnt;
      src_rand = 1'b1;
      push_exp(5, 4, 8);
      kick(5, 4, 8);
      wait_done(1000, lat);
      src_rand = 1'b0;
      n_tests++;
      if (lat < 23) begin
         n_fail++;
         $display("FAIL stall_done_seen: got latency %0d, expected >= 23", lat);
      end
      check_int("stall_write_count", wr_cnt - w0, 20);
      check_int("stall_accept_count", acc_cnt - a0, 20);
      check_int("stall_queue_left", exp_q.size(), 0);
      step();
   endtask

   task automatic test_abort();
      int lat, w0, a0, n;
      w0 = wr_cnt;
      a0 = acc_cnt;
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      n = 0;
      while (acc_cnt - a0 < 7 && n < 100) begin
         step();
         start = 1'b0;
         n++;
      end
      check_int("abort_reached_word7", int'(acc_cnt - a0 >= 7), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_int("abort_done_pulse", int'(done), 1);
      check_int("abort_read_low", int'(rd), 0);
      check_int("abort_write_count", wr_cnt - w0, 7);
      check_int("abort_accept_count", acc_cnt - a0, 7);
      step();
      check_int("abort_idle_busy", int'(busy), 0);
      exp_q.delete();
      w0 = wr_cnt;
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      wait_done(200, lat);
      check_int("abort_restart_latency", lat, 15);
      check_int("abort_restart_writes", wr_cnt - w0, 12);
      check_int("abort_restart_queue", exp_q.size(), 0);
      step();
   endtask

   task automatic test_start_edge();
      int lat, w0, a0;
      w0 = wr_cnt;
      a0 = acc_cnt;
      kick(4, 0, 0);
      wait_done(5, lat);
      check_int("zero_rows_done_next", lat, 1);
      check_int("zero_rows_read", int'(rd), 0);
      step();
      check_int("zero_rows_done_clears", int'(done), 0);
      kick(0, 3, 0);
      wait_done(5, lat);
      check_int("zero_cols_done_next", lat, 1);
      step();
      check_int("zero_cfg_writes", wr_cnt - w0, 0);
      check_int("zero_cfg_accepts", acc_cnt - a0, 0);
      // Restart and config churn while busy must not disturb the transfer
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      step();
      start = 1'b0;
      step();
      step();
      check_int("busy_during_load", int'(busy), 1);
      kick(7, 9, 100);
      step();
      start = 1'b0;
      wait_done(200, lat);
      check_int("busy_start_latency", lat, 11);
      check_int("busy_start_writes", wr_cnt - w0, 12);
      check_int("busy_start_queue", exp_q.size(), 0);
      step();
      check_int("busy_start_no_rerun", int'(busy), 0);
   endtask

   task automatic test_wrap_1bank();
      int  n;
      wr_t e;
      int  want;
      obs1_q.delete();
      cfg_rw1 = 10'd16;
      cfg_rows1 = 8'd2;
      cfg_base1 = 11'd2040;
      start1 = 1'b1;
      n = 0;
      do begin
         step();
         start1 = 1'b0;
         cfg_base1 = 11'd5;
         n++;
      end while (!done1 && n < 200);
      check_int("wrap_done_seen", int'(done1), 1);
      check_int("wrap_write_count", obs1_q.size(), 32);
      for (int j = 0; j < 32 && obs1_q.size() > 0; j++) begin
         e = obs1_q.pop_front();
         want = (2040 + (j / 16) * 16 + (j % 16)) % 2048;
         n_tests++;
         if (e.addr !== AB'(want) || e.data !== word(8'h66, j) || e.cen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_write[%0d]: got addr=%0d data=%h wen=%b, expected addr=%0d data=%h wen=0",
                     j, e.addr, e.data, e.cen[0], want, word(8'h66, j));
         end
      end
      step();
   endtask

   task automatic test_reset_mid();
      int lat, a0, n, w0;
      a0 = acc_cnt;
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      n = 0;
      while (acc_cnt - a0 < 5 && n < 100) begin
         step();
         start = 1'b0;
         n++;
      end
      check_int("midreset_busy_before", int'(busy), 1);
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset_outputs");
      step();
      check_idle_outputs("midreset_hold");
      reset = 1'b1;
      exp_q.delete();
      step();
      w0 = wr_cnt;
      push_exp(4, 3, 0);
      kick(4, 3, 0);
      wait_done(200, lat);
      check_int("midreset_rerun_latency", lat, 15);
      check_int("midreset_rerun_writes", wr_cnt - w0, 12);
      check_int("midreset_rerun_queue", exp_q.size(), 0);
      step();
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_long_rows();
      test_stall();
      test_abort();
      test_start_edge();
      test_wrap_1bank();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
